// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory controller: funct3 codes,
// FSM states, byte-enable generation, load extension and access checks.
package dmem_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam int unsigned WS_CNT_W = 4;

    // Byte enables for a store at the given byte offset.
    function automatic logic [3:0] be_gen(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3)
            F3_B:    be = 4'b0001 << off;
            F3_H:    be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data copied onto every lane it may land in.
    function automatic logic [31:0] store_repl(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        case (f3)
            F3_B:    r = {4{d[7:0]}};
            F3_H:    r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Select the addressed lane of a RAM word and extend it to 32 bits.
    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_BU:   r = {24'b0, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_HU:   r = {16'b0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic m;
        case (f3)
            F3_H, F3_HU: m = off[0];
            F3_W:        m = (off != 2'b00);
            default:     m = 1'b0;
        endcase
        return m;
    endfunction

    // Stores only exist as B/H/W; loads reject the three unused codes.
    function automatic logic is_illegal(input logic we, input logic [2:0] f3);
        logic ill;
        if (we) begin
            ill = !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
        end else begin
            ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        return ill;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Load/store bus between the core LSU (master) and the data-memory controller (slave).
interface dmem_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req;
    logic              we;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, funct3, addr, wdata,
        input  ready, done, err, rdata
    );

    modport slave (
        input  req, we, funct3, addr, wdata,
        output ready, done, err, rdata
    );
endinterface

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM with per-byte write enables.
// Registered read output, contents are never reset.
module dmem_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned DATA_W      = 32,
    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS),
    localparam int unsigned NB         = DATA_W / 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [NB-1:0]     be,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Byte-lane writes and registered read; rdata holds between reads.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (en) begin
            rdata <= mem[idx];
        end
    end
endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: req/ready/done handshake in front of dmem_ram with
// programmable read wait states, B/H/W accesses with sign/zero extension and
// misalign/illegal-op error reporting.
// Optional feature: define DMEM_MMIO_EN to decode MMIO_BASE to a 32-bit
// register driving gpio_o (word access only, no RAM access at that address).
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
`ifdef DMEM_MMIO_EN
    ,
    parameter logic [ADDR_W-1:0] MMIO_BASE = 32'h8000_0000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    dmem_if.slave       bus
`ifdef DMEM_MMIO_EN
    ,
    output logic [31:0] gpio_o
`endif
);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    state_e                state_q, state_d;
    logic [IDX_W+1:0]      addr_q;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [WS_CNT_W-1:0]   cnt_q;
    logic                  err_q;
    logic                  mmio_q;
    logic [DATA_W-1:0]     rdata_q;

    logic                  accept;
    logic                  mmio_hit;
    logic                  req_err;

    logic                  ram_en;
    logic                  ram_we;
    logic [3:0]            ram_be;
    logic [IDX_W-1:0]      ram_idx;
    logic [DATA_W-1:0]     ram_wdata;
    logic [DATA_W-1:0]     ram_rdata;

`ifdef DMEM_MMIO_EN
    logic [31:0]           gpio_q;
    assign gpio_o = gpio_q;
`else
    // Address bits above the RAM index are ignored so accesses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[ADDR_W-1:IDX_W+2];
`endif

    // Handshake outputs: a new request may be taken while idle or on the done cycle.
    assign bus.ready = (state_q == IDLE) || (state_q == RESP);
    assign bus.done  = (state_q == RESP);
    assign bus.err   = (state_q == RESP) && err_q;
    assign bus.rdata = rdata_q;
    assign accept    = bus.req && bus.ready;

    // Decode the incoming request: MMIO hit and error conditions.
    always_comb begin
        mmio_hit = 1'b0;
`ifdef DMEM_MMIO_EN
        mmio_hit = (bus.addr == MMIO_BASE);
`endif
        req_err = is_illegal(bus.we, bus.funct3)
               || is_misaligned(bus.funct3, bus.addr[1:0])
               || (mmio_hit && (bus.funct3 != F3_W));
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, RESP: begin
                if (!accept) begin
                    state_d = IDLE;
                end else if (req_err) begin
                    state_d = RESP;
                end else if (bus.we) begin
                    state_d = WR;
                end else if (mmio_hit) begin
                    state_d = RESP;
                end else begin
                    state_d = RD;
                end
            end
            RD: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end
            end
            WR: state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the request fields on accept so later input changes cannot disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            wdata_q <= '0;
            err_q   <= 1'b0;
            mmio_q  <= 1'b0;
        end else if (accept) begin
            addr_q  <= bus.addr[IDX_W+1:0];
            we_q    <= bus.we;
            f3_q    <= bus.funct3;
            wdata_q <= bus.wdata;
            err_q   <= req_err;
            mmio_q  <= mmio_hit;
        end
    end

    // Wait-state counter and load result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            rdata_q <= '0;
        end else if (accept) begin
            cnt_q <= WS_CNT_W'(WAIT_STATES);
            if (req_err) begin
                rdata_q <= '0;
            end
`ifdef DMEM_MMIO_EN
            else if (mmio_hit && !bus.we) begin
                rdata_q <= gpio_q;
            end
`endif
        end else if (state_q == RD) begin
            if (cnt_q == '0) begin
                rdata_q <= load_ext(f3_q, addr_q[1:0], ram_rdata);
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

`ifdef DMEM_MMIO_EN
    // MMIO register: written by a word store to MMIO_BASE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_q <= '0;
        end else if ((state_q == WR) && mmio_q) begin
            gpio_q <= wdata_q;
        end
    end
`endif

    // RAM port: reads issue on the accept edge, writes happen on the WR edge.
    always_comb begin
        ram_en    = accept && !bus.we && !req_err && !mmio_hit;
        ram_we    = (state_q == WR) && we_q && !mmio_q;
        ram_be    = be_gen(f3_q, addr_q[1:0]);
        ram_idx   = accept ? bus.addr[IDX_W+1:2] : addr_q[IDX_W+1:2];
        ram_wdata = store_repl(f3_q, wdata_q);
    end

    dmem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .DATA_W     (DATA_W)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .be   (ram_be),
        .idx  (ram_idx),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl (WAIT_STATES=1); honours DMEM_MMIO_EN.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    dmem_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef DMEM_MMIO_EN
    logic [31:0] gpio;
    dmem_ctrl #(
        .DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(1024), .WAIT_STATES(1), .MMIO_BASE(MMIO_BASE)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .gpio_o(gpio)
    );
`else
    dmem_ctrl #(
        .DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(1024), .WAIT_STATES(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction; lat counts clock edges from the accept edge to done visible.
    task automatic access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, output int lat, output logic [31:0] rd,
                          output logic e);
        bit got;
        @(negedge clk);
        check("ready_before_req", {31'b0, bus.ready}, 32'd1);
        bus.req    = 1'b1;
        bus.we     = w;
        bus.funct3 = f3;
        bus.addr   = a;
        bus.wdata  = d;
        lat = 0;
        got = 0;
        while (!got && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) bus.req = 1'b0;
            if (bus.done) got = 1;
        end
        rd = bus.rdata;
        e  = bus.err;
        check("done_timeout", {31'b0, got}, 32'd1);
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d);
        int lat;
        logic [31:0] rd;
        logic e;
        access(1'b1, f3, a, d, lat, rd, e);
        check({tag, "_lat"}, 32'(lat), 32'd2);
        check({tag, "_err"}, {31'b0, e}, 32'd0);
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] exp);
        int lat;
        logic [31:0] rd;
        logic e;
        access(1'b0, f3, a, 32'h0, lat, rd, e);
        check({tag, "_lat"}, 32'(lat), 32'd3);
        check({tag, "_err"}, {31'b0, e}, 32'd0);
        check({tag, "_data"}, rd, exp);
    endtask

    task automatic do_error(input string tag, input logic w, input logic [2:0] f3,
                            input logic [31:0] a);
        int lat;
        logic [31:0] rd;
        logic e;
        access(w, f3, a, 32'hFFFF_FFFF, lat, rd, e);
        check({tag, "_lat"}, 32'(lat), 32'd1);
        check({tag, "_err"}, {31'b0, e}, 32'd1);
        check({tag, "_data"}, rd, 32'h0);
    endtask

    initial begin
        int lat;
        logic [31:0] rd;
        logic e;
        n_cmp  = 0;
        n_fail = 0;
        rst        = 1'b1;
        bus.req    = 1'b0;
        bus.we     = 1'b0;
        bus.funct3 = 3'b000;
        bus.addr   = '0;
        bus.wdata  = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, bus.ready}, 32'd1);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_err", {31'b0, bus.err}, 32'd0);
        check("rst_rdata", bus.rdata, 32'h0);
`ifdef DMEM_MMIO_EN
        check("rst_gpio", gpio, 32'h0);
`endif
        rst = 1'b0;

        // Basic word store/load and lane extraction.
        do_store("sw0", F3_W, 32'h00, 32'h0BAD_F00D);
        do_store("sw10", F3_W, 32'h10, 32'hDEAD_BEEF);
        do_load("lw10", F3_W, 32'h10, 32'hDEAD_BEEF);
        do_load("lb13", F3_B, 32'h13, 32'hFFFF_FFDE);
        do_load("lbu13", F3_BU, 32'h13, 32'h0000_00DE);
        do_load("lh12", F3_H, 32'h12, 32'hFFFF_DEAD);
        do_load("lhu10", F3_HU, 32'h10, 32'h0000_BEEF);

        // Partial stores.
        do_store("sb11", F3_B, 32'h11, 32'h0000_0055);
        do_load("lw_sb", F3_W, 32'h10, 32'hDEAD_55EF);
        do_store("sh12", F3_H, 32'h12, 32'h0000_1234);
        do_load("lw_sh", F3_W, 32'h10, 32'h1234_55EF);

        // Errors: misaligned and illegal codes, memory left untouched.
        do_error("lw_mis", 1'b0, F3_W, 32'h02);
        do_error("sh_mis", 1'b1, F3_H, 32'h01);
        do_error("ld_011", 1'b0, 3'b011, 32'h00);
        do_error("st_100", 1'b1, 3'b100, 32'h04);
        do_load("lw0_after_err", F3_W, 32'h00, 32'h0BAD_F00D);

        // Upper address bits wrap onto the RAM index.
        do_load("lw_wrap", F3_W, 32'h0000_1010, 32'h1234_55EF);

        // Request while busy is ignored, latched fields are unaffected.
        do_store("sw24", F3_W, 32'h24, 32'h3333_3333);
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b0; bus.funct3 = F3_W; bus.addr = 32'h10;
        @(posedge clk); #1;
        check("busy_ready", {31'b0, bus.ready}, 32'd0);
        bus.we = 1'b1; bus.addr = 32'h24; bus.wdata = 32'h7777_7777; bus.funct3 = F3_B;
        @(posedge clk); #1;
        check("busy_done_early", {31'b0, bus.done}, 32'd0);
        bus.req = 1'b0;
        @(posedge clk); #1;
        check("busy_done", {31'b0, bus.done}, 32'd1);
        check("busy_rdata", bus.rdata, 32'h1234_55EF);
        do_load("lw24_untouched", F3_W, 32'h24, 32'h3333_3333);

        // Reset during WR aborts the store.
        do_store("sw20", F3_W, 32'h20, 32'h1111_1111);
        do_load("lw_pre_rst", F3_W, 32'h10, 32'h1234_55EF);
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = F3_W; bus.addr = 32'h20;
        bus.wdata = 32'h2222_2222;
        @(posedge clk); #1;
        bus.req = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_ready", {31'b0, bus.ready}, 32'd1);
        check("midrst_done", {31'b0, bus.done}, 32'd0);
        check("midrst_err", {31'b0, bus.err}, 32'd0);
        check("midrst_rdata", bus.rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        do_load("lw20_old", F3_W, 32'h20, 32'h1111_1111);

`ifdef DMEM_MMIO_EN
        do_store("sw_mmio", F3_W, MMIO_BASE, 32'h0000_00A5);
        check("gpio_val", gpio, 32'h0000_00A5);
        access(1'b0, F3_W, MMIO_BASE, 32'h0, lat, rd, e);
        check("lw_mmio_lat", 32'(lat), 32'd1);
        check("lw_mmio_err", {31'b0, e}, 32'd0);
        check("lw_mmio_data", rd, 32'h0000_00A5);
        do_error("sb_mmio", 1'b1, F3_B, MMIO_BASE);
        check("gpio_keep", gpio, 32'h0000_00A5);
        do_load("lw0_no_alias", F3_W, 32'h00, 32'h0BAD_F00D);
`else
        do_store("sw_alias", F3_W, MMIO_BASE, 32'hCAFE_F00D);
        do_load("lw0_alias", F3_W, 32'h00, 32'hCAFE_F00D);
        access(1'b0, F3_W, MMIO_BASE, 32'h0, lat, rd, e);
        check("lw_alias_data", rd, 32'hCAFE_F00D);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
